sram_row_feeder: RTL
====================

# sram_row_feeder

Writer-side companion of the horizontal line buffer FIFO. On a `start` pulse it reads `row_len` consecutive bytes from the feature SRAM, starting at `base_addr`. It pushes them in order into the FIFO through the `fifo_WVALID`/`fifo_WREADY` handshake. It hides the SRAM's fixed 1-cycle read latency behind a 2-entry holding buffer, so throughput is one byte per cycle while the FIFO accepts and no byte is ever lost when the FIFO fills.

## Interface
- `DATA_W`, 8: byte width. Must match the FIFO's `BUF_DATA_SIZE`.
- `ADDR_W`, 16: SRAM address width.
- `LEN_W`, 10: width of the row length.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request. Sampled only in IDLE.
- `base_addr`  in  ADDR_W  first SRAM address. Sampled with `start`.
- `row_len`  in  LEN_W  number of bytes to transfer. Sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a job.
- `sram_ce`  out  1  SRAM read enable.
- `sram_addr`  out  ADDR_W  SRAM read address.
- `sram_rdata`  in  DATA_W  SRAM read data. Valid the cycle after `sram_ce`.
- `fifo_WVALID`  out  1  a byte is presented on `buf_in`.
- `fifo_WREADY`  in  1  FIFO not full.
- `buf_in`  out  DATA_W  byte to the FIFO. Always the oldest held byte.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - `start`=1 latches `base_addr` and `row_len`, and clears `issued_cnt` and `sent_cnt`.
  - Goes to RUN if `row_len`≠0, otherwise to DONE.
- RUN:
  - A read issues when `held + inflight − pop < 2`.
    - `held` is the number of bytes in the holding buffer (0..2).
    - `inflight` is 1 if `sram_ce` was high in the previous cycle.
    - `pop` = `fifo_WVALID && fifo_WREADY`.
  - When a read issues: `sram_ce`=1, `sram_addr` = `base_addr` + `issued_cnt` (mod 2^ADDR_W), and `issued_cnt` increments.
  - When `issued_cnt` reaches `row_len` on the last issue, go to DRAIN.
- DRAIN: no reads are issued. When `sent_cnt` = `row_len` after a pop, go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Holding buffer:
  - 2-entry FIFO of bytes.
  - The cycle after an issue, `sram_rdata` is pushed into it at that cycle's end.
  - `fifo_WVALID` = (`held` ≠ 0).
  - A pop removes the head and increments `sent_cnt`.
  - A push and a pop in the same cycle are both honoured.
- `fifo_WVALID` never deasserts while waiting, and `buf_in` is stable while `fifo_WVALID`=1 and `fifo_WREADY`=0.
- `start` outside IDLE is ignored. The latched parameters do not change mid-job.
- Counters are LEN_W bits wide. `row_len` maximum is 2^LEN_W−1.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `sram_ce`=0, `sram_addr`=0, `fifo_WVALID`=0, `buf_in`=0.
  - State is IDLE, and all counters and the holding buffer are cleared.
- Start latency:
  - `start` is sampled at edge E0.
  - The first `sram_ce` is in the cycle after E0.
  - The first `fifo_WVALID` comes 2 cycles after the first `sram_ce`.
- Steady state with `fifo_WREADY` held high: one `sram_ce` and one pop per cycle.
- Back-pressure:
  - When `fifo_WREADY` falls, at most 2 bytes are outstanding (held + inflight).
  - Issue stalls until a pop frees a slot.
  - Issue resumes in the same cycle the pop occurs.
- `done`:
  - Asserted the cycle after the last pop.
  - For `row_len`=0, asserted 1 cycle after `start` is sampled (the DONE cycle), with no `sram_ce`.
  - `busy` falls in the cycle after `done`.
- Address wrap: `base_addr` near 2^ADDR_W−1 wraps to 0 with no error.
- Reset mid-job:
  - Immediate return to the reset values.
  - No `done` pulse, and held bytes are discarded.

## Test plan
- `base_addr`=0x0010, `row_len`=4, `fifo_WREADY`=1:
  - `sram_ce` on 4 consecutive cycles, addresses 0x10 to 0x13.
  - `buf_in` carries the 4 SRAM bytes in order on consecutive cycles.
  - `done` pulses once, one cycle after the 4th pop.
- `row_len`=8 with `fifo_WREADY` low for cycles 3–7 of the job:
  - `fifo_WVALID` stays high with `buf_in` stable.
  - No more than 2 bytes outstanding.
  - All 8 bytes arrive in order, and `sent_cnt`=8 at `done`.
- Connect to the real Sync_v2_FIFO (depth 4) with the reader idle, `row_len`=6:
  - Exactly 4 bytes enter the FIFO and 2 are held, and the job stalls.
  - Then enable the reader: all 6 bytes are read out in order, then `done`.
- `row_len`=0: `done` one cycle after `start`, with no `sram_ce` and no `fifo_WVALID`.
- `base_addr`=0xFFFE, `row_len`=4: `sram_addr` sequence is 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Drive `rst_n` low mid-job (after 3 pops of 8), then start a new job with `row_len`=2:
  - All outputs are 0 during reset, and no `done` pulse appears for the aborted job.
  - The new job transfers exactly 2 fresh bytes.

Source files
------------

// File: rtl/sram_row_feeder.sv
// Purpose : streams row_len bytes from the feature SRAM (base_addr onward) into the line-buffer FIFO.
// Latency : start sampled at E0 -> first sram_ce the next cycle -> first fifo_WVALID two cycles later.
// Backpres: fifo_WREADY low stalls reads once held + inflight reaches 2; no byte is dropped.
// Ports   : clk/rst_n (async active-low); start/base_addr/row_len job request; busy/done status;
//           sram_ce/sram_addr/sram_rdata SRAM read port (1-cycle latency);
//           fifo_WVALID/fifo_WREADY/buf_in FIFO write side.
module sram_row_feeder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  row_len,
  output logic              busy,
  output logic              done,
  output logic              sram_ce,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              fifo_WVALID,
  input  logic              fifo_WREADY,
  output logic [DATA_W-1:0] buf_in
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_cnt;
  logic [LEN_W-1:0]  sent_cnt;
  logic              inflight;   // a read was issued last cycle; its data is on sram_rdata now
  logic [1:0]        held;       // bytes in the holding buffer
  logic [DATA_W-1:0] hb0;        // head (oldest byte)
  logic [DATA_W-1:0] hb1;
  logic              pop;
  logic              issue;
  logic              slot_free;
  logic [2:0]        occ;

  assign fifo_WVALID = (held != 2'd0);
  assign buf_in      = hb0;
  assign pop         = fifo_WVALID && fifo_WREADY;

  // A slot is free when held + inflight - pop < 2. A pop this cycle frees a
  // slot immediately so that steady state sustains one byte per cycle.
  assign occ       = {1'b0, held} + {2'b0, inflight};
  assign slot_free = pop ? (occ <= 3'd2) : (occ < 3'd2);

  assign sram_ce   = issue;
  assign sram_addr = issue ? (base_q + ADDR_W'(issued_cnt)) : '0;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (row_len == '0) ? DONE : RUN;
      end
      RUN: begin
        // RUN is only entered/kept while issued_cnt < len_q.
        if (slot_free) begin
          issue = 1'b1;
          if ((issued_cnt + LEN_W'(1)) == len_q) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && ((sent_cnt + LEN_W'(1)) == len_q)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_cnt <= '0;
      sent_cnt   <= '0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (state == IDLE && start) begin
        base_q     <= base_addr;
        len_q      <= row_len;
        issued_cnt <= '0;
        sent_cnt   <= '0;
      end else begin
        if (issue) issued_cnt <= issued_cnt + LEN_W'(1);
        if (pop)   sent_cnt   <= sent_cnt + LEN_W'(1);
      end
    end
  end

  // Holding buffer: push = read data returning this cycle, pop = FIFO accept.
  // The issue rule guarantees a push never arrives with two bytes held and no pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= 2'd0;
      hb0  <= '0;
      hb1  <= '0;
    end else begin
      held <= held + {1'b0, inflight} - {1'b0, pop};
      case ({inflight, pop})
        2'b11: begin
          if (held == 2'd2) begin
            hb0 <= hb1;
            hb1 <= sram_rdata;
          end else begin
            hb0 <= sram_rdata;
          end
        end
        2'b10: begin
          if (held == 2'd0) hb0 <= sram_rdata;
          else              hb1 <= sram_rdata;
        end
        2'b01: begin
          if (held == 2'd2) hb0 <= hb1;
        end
        default: ;
      endcase
    end
  end

endmodule
